// File: rtl/uart_rx_param.sv
// 16x-oversampled UART receiver with configurable width, parity and stop bits.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote.
module uart_rx_param #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_CALC = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
    localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic ODD    = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

    state_t               state, state_nx;
    logic                 rx_meta, rxs, rxs_d;
    logic [PW-1:0]        pre;
    logic                 tick;
    logic [3:0]           sc;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr, ferr_final;
    logic                 start_edge, samp_tick, samp_bit, deliver;
    logic                 parity_calc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign start_edge = (state == IDLE) && rxs_d && !rxs;
    assign tick       = (pre == PW'(DIV - 1));

    // Prescaler realigns to the start edge so sample points sit mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pre <= '0;
        else if (start_edge || tick) pre <= '0;
        else                         pre <= pre + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              sc <= '0;
        else if (state == IDLE)  sc <= '0;
        else if (tick)           sc <= sc + 4'd1;
    end

`ifdef UART_RX_MAJORITY_EN
    logic s6, s7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s6 <= 1'b1;
            s7 <= 1'b1;
        end else if (tick) begin
            if (sc == 4'd6) s6 <= rxs;
            if (sc == 4'd7) s7 <= rxs;
        end
    end

    assign samp_tick = tick && (sc == 4'd8);
    assign samp_bit  = (s6 & s7) | (s6 & rxs) | (s7 & rxs);
`else
    assign samp_tick = tick && (sc == 4'd7);
    assign samp_bit  = rxs;
`endif

    assign parity_calc = (^shreg) ^ ODD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start_edge) state_nx = START;
            START:     if (samp_tick) state_nx = samp_bit ? IDLE : DATA;
            DATA:      if (samp_tick && bit_cnt == 4'(DATA_BITS - 1))
                           state_nx = (PARITY != 0) ? PAR : STOP;
            PAR:       if (samp_tick) state_nx = STOP;
            STOP:      if (samp_tick && bit_cnt == 4'(STOP_BITS - 1))
                           state_nx = samp_bit ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxs) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        deliver    = 1'b0;
        ferr_final = ferr;
        if (state == STOP && samp_tick) begin
            ferr_final = ferr | ~samp_bit;
            deliver    = (bit_cnt == 4'(STOP_BITS - 1));
        end
    end

    // Bit counter restarts on every state change, so it indexes bits within DATA and STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (state_nx != state)
                bit_cnt <= '0;
            else if (samp_tick && (state == DATA || state == STOP))
                bit_cnt <= bit_cnt + 4'd1;

            if (start_edge) begin
                perr <= 1'b0;
                ferr <= 1'b0;
            end
            if (samp_tick) begin
                if (state == DATA) shreg <= {samp_bit, shreg[DATA_BITS-1:1]};
                if (state == PAR)  perr  <= (samp_bit != parity_calc);
                if (state == STOP) ferr  <= ferr_final;
            end
        end
    end

    // A word arriving while the previous one is unaccepted is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (deliver) begin
            if (!valid || ready) begin
                data       <= shreg;
                frame_err  <= ferr_final;
                parity_err <= perr && (PARITY != 0);
                valid      <= 1'b1;
                if (valid) overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E2 instance.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_a = 1'b1, ready_a = 1'b1;
    logic       rx_b = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
    logic       valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .data(data_a), .valid(valid_a), .ready(ready_a),
        .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data(data_b), .valid(valid_b), .ready(ready_b),
        .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       ovr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_idle_a = 0;
    bit   chk_idle_b = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: what the receiver should report for the bit sequence actually put on the line.
    function automatic exp_t model_frame(input logic [7:0] w, input int parity_mode, input logic par_bit,
                                         input logic [1:0] stops, input int nstop, input logic ovr);
        exp_t e;
        int   ones;
        e.data = w;
        e.ovr  = ovr;
        ones   = $countones(w) + int'(par_bit);
        if (parity_mode == 2)      e.perr = (ones % 2) != 0;
        else if (parity_mode == 1) e.perr = (ones % 2) == 0;
        else                       e.perr = 1'b0;
        e.ferr = 1'b0;
        for (int s = 0; s < nstop; s++)
            if (stops[s] == 1'b0) e.ferr = 1'b1;
        return e;
    endfunction

    task automatic drive_rx(input int dut, input logic b);
        if (dut == 0) rx_a = b;
        else          rx_b = b;
    endtask

    task automatic send_frame(input int dut, input logic [7:0] w, input logic par_en, input logic par_bit,
                              input logic [1:0] stops, input int nstop);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        if (par_en) bits.push_back(par_bit);
        for (int s = 0; s < nstop; s++) bits.push_back(stops[s]);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            drive_rx(dut, bits[k]);
            repeat (BIT_CLKS) @(posedge clk);
        end
    endtask

    task automatic apply_stimulus_a(input logic [7:0] w, input logic stop_bit, input logic ovr);
        q_a.push_back(model_frame(w, 0, 1'b0, {1'b1, stop_bit}, 1, ovr));
        send_frame(0, w, 1'b0, 1'b0, {1'b1, stop_bit}, 1);
    endtask

    task automatic apply_stimulus_b(input logic [7:0] w, input logic par_bit, input logic [1:0] stops);
        q_b.push_back(model_frame(w, 2, par_bit, stops, 2, 1'b0));
        send_frame(1, w, 1'b1, par_bit, stops, 2);
    endtask

    // Monitors: pop the scoreboard on each handshake and check the word is released afterwards.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n) begin
            if (chk_idle_a) begin
                check_output("a_valid_after_accept", valid_a, 0);
                check_output("a_overrun_after_accept", overrun_a, 0);
                chk_idle_a = 0;
            end
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL a_unexpected_word: got data 0x%0h, expected no word", data_a);
                end else begin
                    e = q_a.pop_front();
                    check_output("a_data", data_a, e.data);
                    check_output("a_frame_err", frame_err_a, e.ferr);
                    check_output("a_parity_err", parity_err_a, e.perr);
                    check_output("a_overrun", overrun_a, e.ovr);
                end
                chk_idle_a = 1;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n) begin
            if (chk_idle_b) begin
                check_output("b_valid_after_accept", valid_b, 0);
                chk_idle_b = 0;
            end
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL b_unexpected_word: got data 0x%0h, expected no word", data_b);
                end else begin
                    e = q_b.pop_front();
                    check_output("b_data", data_b, e.data);
                    check_output("b_frame_err", frame_err_b, e.ferr);
                    check_output("b_parity_err", parity_err_b, e.perr);
                    check_output("b_overrun", overrun_b, e.ovr);
                end
                chk_idle_b = 1;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] w;
        logic [1:0] st;
        logic       pb;

        #2 rst_n = 1'b0;
        #20;
        check_output("reset_data_a", data_a, 0);
        check_output("reset_valid_a", valid_a, 0);
        check_output("reset_busy_a", busy_a, 0);
        check_output("reset_overrun_a", overrun_a, 0);
        check_output("reset_valid_b", valid_b, 0);
        check_output("reset_flags_b", {frame_err_b, parity_err_b, overrun_b, busy_b}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);

        $display("[TB] basic 8N1 word");
        apply_stimulus_a(8'hA5, 1'b1, 1'b0);

        $display("[TB] even parity, wrong then right");
        apply_stimulus_b(8'h3C, 1'b1, 2'b11);
        apply_stimulus_b(8'h3C, 1'b0, 2'b11);

        $display("[TB] overrun");
        ready_a = 1'b0;
        apply_stimulus_a(8'h11, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 2'b11, 1);
        #1;
        check_output("ovr_hold_data", data_a, 8'h11);
        check_output("ovr_hold_valid", valid_a, 1);
        check_output("ovr_flag", overrun_a, 1);
        @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1 ready_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 ready_a = 1'b1;
        apply_stimulus_a(8'h33, 1'b1, 1'b0);

        $display("[TB] start glitch");
        rx_a = 1'b0;
        repeat (30) @(posedge clk);
        #1 check_output("glitch_busy_high", busy_a, 1);
        repeat (20) @(posedge clk);
        rx_a = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        #1 check_output("glitch_busy_low", busy_a, 0);
        apply_stimulus_a(8'h5A, 1'b1, 1'b0);

        $display("[TB] break");
        q_a.push_back(model_frame(8'h00, 0, 1'b0, 2'b00, 1, 1'b0));
        rx_a = 1'b0;
        repeat (15 * BIT_CLKS) @(posedge clk);
        #1 check_output("break_wait_busy", busy_a, 1);
        repeat (5 * BIT_CLKS) @(posedge clk);
        rx_a = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1 check_output("break_idle_busy", busy_a, 0);
        apply_stimulus_a(8'h96, 1'b1, 1'b0);

        $display("[TB] reset mid-frame");
        rx_a = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        rx_a = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 check_output("midframe_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check_output("midreset_data_a", data_a, 0);
        check_output("midreset_busy_a", busy_a, 0);
        check_output("midreset_flags_a", {valid_a, frame_err_a, parity_err_a, overrun_a}, 0);
        check_output("midreset_data_b", data_b, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (9 * BIT_CLKS) @(posedge clk);
        apply_stimulus_a(8'h81, 1'b1, 1'b0);

        $display("[TB] randomized frames");
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    apply_stimulus_a(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
                end
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    w  = 8'($urandom);
                    pb = 1'($countones(w) % 2) ^ ($urandom_range(0, 3) == 0);
                    st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                    apply_stimulus_b(w, pb, st);
                end
            end
        join

        for (int c = 0; c < 4 * BIT_CLKS; c++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
        end
        check_output("a_queue_drained", q_a.size(), 0);
        check_output("b_queue_drained", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8N1 byte receiver.
- Receives asynchronous serial frames on `rx` using 16x oversampling from the system `clk`. No derived clock.
- Supports configurable data width, parity mode and stop-bit count.
- Presents each received word on a valid/ready output register with frame, parity and overrun status. Sits between the Bluetooth module's TX pin and downstream consumers (display mux, command parser).

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in baud.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, LSB first.
- data  output  DATA_BITS  received word.
- valid  output  1  data/status held valid until accepted.
- ready  input  1  consumer accepts when valid & ready at posedge.
- frame_err  output  1  a stop bit sampled 0 in the presented word.
- parity_err  output  1  parity mismatch in the presented word; always 0 when PARITY=0.
- overrun  output  1  sticky; at least one frame was dropped since the last accept.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - One clock domain (clk); reset is asynchronous and active-low (rst_n).
  - Reset values: data=0, valid=0, frame_err=0, parity_err=0, overrun=0, busy=0; FSM in IDLE; prescaler=0.
  - Reset asserted mid-frame aborts the frame; nothing is delivered.
- Input synchronisation: `rx` passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised `rxs`.
- Prescaler:
  - DIV = round(CLK_HZ/(BAUD*16)), minimum 1.
  - Counter 0..DIV-1 emits a 1-cycle `tick` at DIV-1.
  - Counter is cleared on the start-edge detection cycle.
  - A 4-bit tick counter `sc` counts 16 ticks per bit.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- IDLE:
  - A falling edge of `rxs` (previous 1, current 0) moves to START with sc=0.
- START: at sc=7 (mid-bit), sample.
  - If 1, treat as a glitch and return to IDLE; nothing is delivered.
  - If 0, reset sc and go to DATA.
- DATA:
  - Sample at mid-bit (sc wraps 15->0 between bits), shifting LSB first into a DATA_BITS shift register.
  - After DATA_BITS samples, go to PAR if PARITY!=0, otherwise to STOP.
- PAR: sample one bit.
  - parity_calc = XOR of data bits, inverted for odd (PARITY=1).
  - Mismatch with the sampled bit sets the internal perr.
- STOP: sample STOP_BITS bits. Any sampled 0 sets the internal ferr. After the last stop sample:
  - Deliver the frame (see Delivery).
  - If the last stop sample was 0 (break/line low), go to WAIT_IDLE; otherwise go to IDLE.
- WAIT_IDLE: stay until `rxs`=1, then go to IDLE. This prevents a break from re-triggering start.
- Delivery occurs on the same posedge as the last stop sample (latency from mid last stop bit to valid = 1 clk). It depends on the output register:
  - valid=0: load data/frame_err/parity_err; set valid=1.
  - valid=1 & ready=1 in the same cycle: accept the old word and load the new one; valid stays 1; overrun cleared.
  - valid=1 & ready=0: new frame discarded; overrun set to 1; output word unchanged.
- Accept: valid & ready with no simultaneous delivery gives valid=0 and overrun=0 on the next edge. data/frame_err/parity_err hold their last values.
- A frame with errors is still delivered, with its flags set.

Optional Feature:
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each bit sample (start, data, parity, stop) is the majority of three `rxs` samples taken at sc=6, 7, 8.
  - The decision is applied at sc=8, so the state advance moves 1 tick later.
  - Start-bit validation uses the majority value.
- Undefined: single sample at sc=7. No extra registers.

Test Plan:
- CLK_HZ=1600000, BAUD=10000 (DIV=10, 160 clk/bit), 8N1, ready=1, send 0xA5 -> valid for exactly 1 clk, data=0xA5, frame_err=0, parity_err=0, overrun=0.
- PARITY=2, send 0x3C with parity 1 (wrong) -> data=0x3C, parity_err=1. Resend with parity 0 -> parity_err=0.
- ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun=1. Pulse ready -> valid=0, overrun=0. Next frame 0x33 is delivered normally.
- rx low pulse of 50 clk while idle -> START is aborted, busy returns 0, no valid. A following 0x5A frame is received correctly.
- Hold rx low for 20 bit times (break) -> one word data=0x00 with frame_err=1. No further valid until rx returns high and a new start arrives.
- Assert rst_n=0 mid-data-bit of 0xFF frame -> all outputs 0 immediately, no delivery. Next full 0x81 frame is received correctly.
